// File: rtl/tag_rx_ctrl_multihop.sv
// tag_rx_ctrl_multihop: tag RX sequencer running LOC_SYNC then NUM_HOPS (HOP_SYNC, HOP_RX) pairs,
// replacing IQ with sync markers during sync phases.  Rev 1.0
`default_nettype none

module tag_rx_ctrl_multihop #(
  parameter int DATA_WIDTH       = 16,
  parameter int LOC_SYNC_N       = 8192,
  parameter int HOP_SYNC_N       = 8192,
  parameter int FIRST_HOP_SYNC_N = 24576,
  parameter int HOP_RX_N         = 16385,
  parameter int NUM_HOPS         = 64,
  parameter int IDLE_LIMIT       = 32768,
  parameter int SYNC_AMP         = 32000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sync_trig,
  input  logic                       scan_trig,
  input  logic                       abort,
  input  logic [DATA_WIDTH-1:0]      irx_in,
  input  logic [DATA_WIDTH-1:0]      qrx_in,
  output logic [DATA_WIDTH-1:0]      irx_out,
  output logic [DATA_WIDTH-1:0]      qrx_out,
  output logic                       rx_valid,
  output logic                       sync_ready,
  output logic [1:0]                 rx_state,
  output logic [$clog2(NUM_HOPS):0]  hop_idx,
  output logic [DATA_WIDTH-1:0]      counter_sync
);

  localparam int HOP_W = $clog2(NUM_HOPS) + 1;

  localparam logic [DATA_WIDTH-1:0] LOC_LOAD   = DATA_WIDTH'(LOC_SYNC_N - 1);
  localparam logic [DATA_WIDTH-1:0] HOP_LOAD   = DATA_WIDTH'(HOP_SYNC_N - 1);
  localparam logic [DATA_WIDTH-1:0] FIRST_LOAD = DATA_WIDTH'(FIRST_HOP_SYNC_N - 1);
  localparam logic [DATA_WIDTH-1:0] RX_LOAD    = DATA_WIDTH'(HOP_RX_N - 1);
  localparam logic [DATA_WIDTH:0]   IDLE_MAX   = (DATA_WIDTH+1)'(IDLE_LIMIT);
  localparam logic [HOP_W-1:0]      LAST_HOP   = HOP_W'(NUM_HOPS - 1);
  localparam logic [DATA_WIDTH-1:0] AMP_POS    = DATA_WIDTH'(SYNC_AMP);
  localparam logic [DATA_WIDTH-1:0] AMP_NEG    = DATA_WIDTH'(-SYNC_AMP);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOC_SYNC = 2'd1,
    ST_HOP_SYNC = 2'd2,
    ST_HOP_RX   = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_counter, w_counter_nxt;
  logic [HOP_W-1:0]      r_hop, w_hop_nxt;
  logic [DATA_WIDTH:0]   r_idle_cnt, w_idle_cnt_nxt;
  logic                  r_rx_valid, w_rx_valid_nxt;
  logic                  r_scan_mode, w_scan_mode_nxt;
  logic                  r_trig_s1, r_trig_s2, r_trig_s3, r_trig_edge;
  logic                  r_scan_s1, r_scan_s2;
  logic                  w_cnt_zero;
  logic [DATA_WIDTH:0]   w_idle_inc;

  // Edge is registered so a pin sampled high at edge k moves the FSM at edge k+3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trig_s1   <= 1'b0;
      r_trig_s2   <= 1'b0;
      r_trig_s3   <= 1'b0;
      r_trig_edge <= 1'b0;
      r_scan_s1   <= 1'b0;
      r_scan_s2   <= 1'b0;
    end else begin
      r_trig_s1   <= sync_trig;
      r_trig_s2   <= r_trig_s1;
      r_trig_s3   <= r_trig_s2;
      r_trig_edge <= r_trig_s2 & ~r_trig_s3;
      r_scan_s1   <= scan_trig;
      r_scan_s2   <= r_scan_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_counter   <= '0;
      r_hop       <= '0;
      r_idle_cnt  <= IDLE_MAX;
      r_rx_valid  <= 1'b0;
      r_scan_mode <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_hop       <= w_hop_nxt;
      r_idle_cnt  <= w_idle_cnt_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_scan_mode <= w_scan_mode_nxt;
    end
  end

  assign w_cnt_zero = (r_counter == '0);
  assign w_idle_inc = r_idle_cnt + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_counter_nxt   = r_counter;
    w_hop_nxt       = r_hop;
    w_idle_cnt_nxt  = r_idle_cnt;
    w_rx_valid_nxt  = r_rx_valid;
    w_scan_mode_nxt = r_scan_mode;
    if (abort) begin
      w_state_nxt    = ST_IDLE;
      w_counter_nxt  = '0;
      w_hop_nxt      = '0;
      w_idle_cnt_nxt = IDLE_MAX;
      w_rx_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_trig_edge) begin
            w_state_nxt     = ST_LOC_SYNC;
            w_counter_nxt   = LOC_LOAD;
            w_hop_nxt       = '0;
            w_rx_valid_nxt  = 1'b1;
            w_scan_mode_nxt = r_scan_s2;
          end else if (r_idle_cnt < IDLE_MAX) begin
            w_idle_cnt_nxt = w_idle_inc;
            if (w_idle_inc == IDLE_MAX) w_rx_valid_nxt = 1'b0;
          end else begin
            w_rx_valid_nxt = 1'b0;
          end
        end
        ST_LOC_SYNC: begin
          if (w_cnt_zero) begin
            w_state_nxt   = ST_HOP_SYNC;
            w_counter_nxt = r_scan_mode ? HOP_LOAD : FIRST_LOAD;
          end else begin
            w_counter_nxt = r_counter - 1'b1;
          end
        end
        ST_HOP_SYNC: begin
          if (w_cnt_zero) begin
            w_state_nxt   = ST_HOP_RX;
            w_counter_nxt = RX_LOAD;
          end else begin
            w_counter_nxt = r_counter - 1'b1;
          end
        end
        ST_HOP_RX: begin
          if (!w_cnt_zero) begin
            w_counter_nxt = r_counter - 1'b1;
          end else if (r_hop == LAST_HOP) begin
            w_state_nxt    = ST_IDLE;
            w_idle_cnt_nxt = '0;
          end else begin
            w_state_nxt   = ST_HOP_SYNC;
            w_hop_nxt     = r_hop + 1'b1;
            w_counter_nxt = HOP_LOAD;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_counter_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    irx_out = irx_in;
    qrx_out = qrx_in;
    case (r_state)
      ST_LOC_SYNC: begin
        irx_out = AMP_NEG;
        qrx_out = '0;
      end
      ST_HOP_SYNC: begin
        irx_out = AMP_POS;
        qrx_out = '0;
      end
      default: begin
        irx_out = irx_in;
        qrx_out = qrx_in;
      end
    endcase
  end

  assign sync_ready   = (r_state == ST_LOC_SYNC) || (r_state == ST_HOP_SYNC);
  assign rx_state     = r_state;
  assign hop_idx      = r_hop;
  assign counter_sync = r_counter;
  assign rx_valid     = r_rx_valid;

endmodule

`default_nettype wire
